// File: rtl/data_mem_unit.sv
// Memory stage: word-organised data RAM with sub-word loads/stores, alignment checking,
// multi-cycle load stall, and the registered writeback mux feeding the register file.
module data_mem_unit #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 8,
    parameter int PC_W       = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        size,
    input  logic              ld_unsigned,
    input  logic [1:0]        wb_sel,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] store_data,
    input  logic [PC_W-1:0]   pc,
    output logic              stall,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_data,
    output logic              misalign
);
    // state | meaning
    // IDLE  | accepting requests; stores complete in the accept cycle
    // WAIT  | load in flight, counting down RAM read latency
    typedef enum logic {IDLE, WAIT} state_t;

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] word_q, word_d;
    logic [1:0]        lane_q, lane_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic              wb_valid_q, wb_valid_d;
    logic              misalign_q, misalign_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;

    logic [ADDR_W-1:0] word;
    logic [1:0]        lane;
    logic              misal, accept, load_go, wr_en;
    logic [NB-1:0]     be;
    logic [DATA_W-1:0] wdata, rd_word, rd_shift, ld_data, pc_ext;
    logic              unused_hi;

    assign word      = alu_result[ADDR_W+1:2];
    assign lane      = alu_result[1:0];
    assign unused_hi = ^alu_result[DATA_W-1:ADDR_W+2];
    assign misal     = ((size == 2'b01) && lane[0]) || (size[1] && (lane != 2'b00));
    assign accept    = (state_q == IDLE) && req_valid;
    assign wr_en     = accept && mem_write && !misal;
    assign load_go   = accept && mem_read && !mem_write && !misal;
    assign stall     = (state_q == WAIT) || load_go;
    assign pc_ext    = {{(DATA_W-PC_W){pc[PC_W-1]}}, pc};

    always_comb begin
        be    = '1;
        wdata = store_data << {lane, 3'b000};
        if (size == 2'b00)      be = NB'(1) << lane;
        else if (size == 2'b01) be = NB'(3) << lane;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (be[b]) mem[word][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    // Read address is captured at accept, so the RAM output is stable throughout WAIT.
    assign rd_word  = mem[word_q];
    assign rd_shift = rd_word >> {lane_q, 3'b000};

    always_comb begin
        ld_data = rd_word;
        if (size_q == 2'b00)
            ld_data = uns_q ? DATA_W'(rd_shift[7:0]) : {{(DATA_W-8){rd_shift[7]}}, rd_shift[7:0]};
        else if (size_q == 2'b01)
            ld_data = uns_q ? DATA_W'(rd_shift[15:0]) : {{(DATA_W-16){rd_shift[15]}}, rd_shift[15:0]};
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        word_d     = word_q;
        lane_d     = lane_q;
        size_d     = size_q;
        uns_d      = uns_q;
        wb_valid_d = 1'b0;
        misalign_d = 1'b0;
        wb_data_d  = wb_data_q;
        if (state_q == IDLE) begin
            if (accept) begin
                if (mem_write) begin
                    misalign_d = misal;
                end else if (mem_read) begin
                    if (misal) begin
                        misalign_d = 1'b1;
                        wb_valid_d = 1'b1;
                        wb_data_d  = '0;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(RD_LATENCY - 1);
                        word_d  = word;
                        lane_d  = lane;
                        size_d  = size;
                        uns_d   = ld_unsigned;
                    end
                end else begin
                    wb_valid_d = 1'b1;
                    case (wb_sel)
                        2'b01:   wb_data_d = '0;
                        2'b10:   wb_data_d = pc_ext + DATA_W'(1);
                        default: wb_data_d = alu_result;
                    endcase
                end
            end
        end else begin
            if (cnt_q == '0) begin
                state_d    = IDLE;
                wb_valid_d = 1'b1;
                wb_data_d  = ld_data;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            word_q     <= '0;
            lane_q     <= '0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            wb_valid_q <= 1'b0;
            misalign_q <= 1'b0;
            wb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            lane_q     <= lane_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            wb_valid_q <= wb_valid_d;
            misalign_q <= misalign_d;
            wb_data_q  <= wb_data_d;
        end
    end

    assign wb_valid = wb_valid_q;
    assign misalign = misalign_q;
    assign wb_data  = wb_data_q;

endmodule

// File: tb/tb_data_mem_unit.sv
// Bench for data_mem_unit: two instances (read latency 1 and 3) checked every cycle
// against a transaction-level model of memory contents and output timing.
module tb_data_mem_unit;
    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        rv_a[2], rd_a[2], wr_a[2], un_a[2];
    logic [1:0]  sz_a[2], ws_a[2];
    logic [31:0] alu_a[2], sd_a[2];
    logic [7:0]  pc_a[2];
    logic        stall_a[2], wbv_a[2], mis_a[2];
    logic [31:0] wbd_a[2];

    data_mem_unit #(.DATA_W(32), .ADDR_W(8), .PC_W(8), .RD_LATENCY(LAT0)) u_dut0 (
        .clk(clk), .rst(rst), .req_valid(rv_a[0]), .mem_read(rd_a[0]), .mem_write(wr_a[0]),
        .size(sz_a[0]), .ld_unsigned(un_a[0]), .wb_sel(ws_a[0]), .alu_result(alu_a[0]),
        .store_data(sd_a[0]), .pc(pc_a[0]), .stall(stall_a[0]), .wb_valid(wbv_a[0]),
        .wb_data(wbd_a[0]), .misalign(mis_a[0]));

    data_mem_unit #(.DATA_W(32), .ADDR_W(8), .PC_W(8), .RD_LATENCY(LAT1)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(rv_a[1]), .mem_read(rd_a[1]), .mem_write(wr_a[1]),
        .size(sz_a[1]), .ld_unsigned(un_a[1]), .wb_sel(ws_a[1]), .alu_result(alu_a[1]),
        .store_data(sd_a[1]), .pc(pc_a[1]), .stall(stall_a[1]), .wb_valid(wbv_a[1]),
        .wb_data(wbd_a[1]), .misalign(mis_a[1]));

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit chk_en = 1'b0;
    int lat[2] = '{LAT0, LAT1};

    logic [31:0] mem_m [2][256];
    bit          stall_set [int];
    bit          wbv_set [int];
    bit          mis_set [int];
    logic [31:0] data_ev [int];
    logic [31:0] last_data [2];
    int          stall_cnt [2];
    int          wbv_cnt [2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    function automatic bit is_mis(input logic [1:0] sz, input logic [31:0] a);
        return ((sz == 2'd1) && a[0]) || (sz[1] && (a[1:0] != 2'd0));
    endfunction

    function automatic logic [31:0] load_val(input int u, input logic [31:0] a,
                                              input logic [1:0] sz, input bit un);
        logic [31:0] w, v;
        int sh;
        w  = mem_m[u][(a >> 2) & 32'hFF];
        sh = 8 * int'(a[1:0]);
        v  = w;
        if (sz == 2'd0) begin
            v = (w >> sh) & 32'hFF;
            if (!un && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (w >> sh) & 32'hFFFF;
            if (!un && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    task automatic store_apply(input int u, input logic [31:0] a, input logic [1:0] sz,
                               input logic [31:0] sd);
        logic [31:0] m;
        int sh;
        sh = 8 * int'(a[1:0]);
        if (sz == 2'd0)      m = 32'hFF << sh;
        else if (sz == 2'd1) m = 32'hFFFF << sh;
        else                 m = 32'hFFFF_FFFF;
        mem_m[u][(a >> 2) & 32'hFF] = (mem_m[u][(a >> 2) & 32'hFF] & ~m) | ((sd << sh) & m);
    endtask

    function automatic logic [31:0] nonmem_val(input logic [1:0] ws, input logic [31:0] alu,
                                                input logic [7:0] p);
        if (ws == 2'b01) return 32'h0;
        if (ws == 2'b10) return {{24{p[7]}}, p} + 32'd1;
        return alu;
    endfunction

    // Applies one request to unit u for one cycle (held while a load stalls) and
    // records in the model when stall, wb_valid and misalign must appear.
    task automatic drive(input int u, input bit rv, input bit rd, input bit wr,
                         input logic [1:0] sz, input bit un, input logic [1:0] ws,
                         input logic [31:0] alu, input logic [31:0] sd, input logic [7:0] p);
        int k, base, hold;
        bit mis;
        @(posedge clk); #1;
        rv_a[u] = rv; rd_a[u] = rd; wr_a[u] = wr; sz_a[u] = sz; un_a[u] = un;
        ws_a[u] = ws; alu_a[u] = alu; sd_a[u] = sd; pc_a[u] = p;
        k = cyc;
        base = u * (1 << 20);
        hold = 0;
        mis = is_mis(sz, alu);
        if (rv) begin
            if (wr) begin
                if (mis) mis_set[base+k+1] = 1'b1;
                else store_apply(u, alu, sz, sd);
            end else if (rd) begin
                if (mis) begin
                    mis_set[base+k+1] = 1'b1;
                    wbv_set[base+k+1] = 1'b1;
                    data_ev[base+k+1] = 32'h0;
                end else begin
                    hold = lat[u];
                    for (int i = 0; i <= hold; i++) stall_set[base+k+i] = 1'b1;
                    wbv_set[base+k+hold+1] = 1'b1;
                    data_ev[base+k+hold+1] = load_val(u, alu, sz, un);
                end
            end else begin
                wbv_set[base+k+1] = 1'b1;
                data_ev[base+k+1] = nonmem_val(ws, alu, p);
            end
        end
        repeat (hold) @(posedge clk);
    endtask

    task automatic idle(input int u, input int n);
        repeat (n) drive(u, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                         2'($urandom_range(0, 3)), $urandom, $urandom, 8'($urandom));
    endtask

    always @(negedge clk) begin
        if (!rst && chk_en) begin
            for (int u = 0; u < 2; u++) begin
                int key;
                bit e_stall, e_wbv, e_mis;
                logic [31:0] e_data;
                key     = u * (1 << 20) + cyc;
                e_stall = stall_set.exists(key) != 0;
                e_wbv   = wbv_set.exists(key) != 0;
                e_mis   = mis_set.exists(key) != 0;
                e_data  = e_wbv ? data_ev[key] : last_data[u];
                chk($sformatf("u%0d_stall", u), 32'(stall_a[u]), 32'(e_stall));
                chk($sformatf("u%0d_wb_valid", u), 32'(wbv_a[u]), 32'(e_wbv));
                chk($sformatf("u%0d_misalign", u), 32'(mis_a[u]), 32'(e_mis));
                chk($sformatf("u%0d_wb_data", u), wbd_a[u], e_data);
                last_data[u] = e_data;
                if (stall_a[u]) stall_cnt[u]++;
                if (wbv_a[u]) wbv_cnt[u]++;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog t=%0t actual=timeout expected=finish", $time);
        $fatal(1, "bench did not finish");
    end

    initial begin
        int s0, w0;
        logic [31:0] a;
        for (int u = 0; u < 2; u++) begin
            rv_a[u] = 0; rd_a[u] = 0; wr_a[u] = 0; un_a[u] = 0; sz_a[u] = 0; ws_a[u] = 0;
            alu_a[u] = 0; sd_a[u] = 0; pc_a[u] = 0;
            last_data[u] = 0; stall_cnt[u] = 0; wbv_cnt[u] = 0;
            for (int w = 0; w < 256; w++) mem_m[u][w] = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            chk("reset_stall", 32'(stall_a[u]), 32'h0);
            chk("reset_wb_valid", 32'(wbv_a[u]), 32'h0);
            chk("reset_misalign", 32'(mis_a[u]), 32'h0);
            chk("reset_wb_data", wbd_a[u], 32'h0);
        end
        rst = 1'b0;
        chk_en = 1'b1;

        // word store then word load, latency 1
        drive(0, 1, 0, 1, 2'd2, 0, 2'd0, 32'h10, 32'hDEAD_BEEF, 8'h0);
        s0 = stall_cnt[0];
        drive(0, 1, 1, 0, 2'd2, 0, 2'd0, 32'h10, 32'h0, 8'h0);
        idle(0, 3);
        chk("t1_stall_cycles", 32'(stall_cnt[0] - s0), 32'd2);
        chk("t1_load_word", wbd_a[0], 32'hDEAD_BEEF);

        // byte store, signed/unsigned byte loads, word readback
        drive(0, 1, 0, 1, 2'd0, 0, 2'd0, 32'h13, 32'h1234_5680, 8'h0);
        drive(0, 1, 1, 0, 2'd0, 0, 2'd2, 32'h13, 32'h0, 8'h7);
        idle(0, 2);
        chk("t2_byte_signed", wbd_a[0], 32'hFFFF_FF80);
        drive(0, 1, 1, 0, 2'd0, 1, 2'd0, 32'h13, 32'h0, 8'h0);
        idle(0, 2);
        chk("t2_byte_unsigned", wbd_a[0], 32'h0000_0080);
        drive(0, 1, 1, 0, 2'd2, 0, 2'd1, 32'h10, 32'h0, 8'h0);
        idle(0, 2);
        chk("t2_word_after_byte", wbd_a[0], 32'h80AD_BEEF);
        chk("t2_model_half_signed", load_val(0, 32'h12, 2'd1, 0), 32'hFFFF_80AD);

        // misaligned half load and word store
        drive(0, 1, 1, 0, 2'd1, 0, 2'd0, 32'h11, 32'h0, 8'h0);
        idle(0, 1);
        chk("t3_ld_misalign", 32'(mis_a[0]), 32'h1);
        chk("t3_ld_wb_valid", 32'(wbv_a[0]), 32'h1);
        chk("t3_ld_wb_data", wbd_a[0], 32'h0);
        drive(0, 1, 0, 1, 2'd2, 0, 2'd0, 32'h12, 32'hFFFF_FFFF, 8'h0);
        idle(0, 1);
        chk("t3_st_misalign", 32'(mis_a[0]), 32'h1);
        chk("t3_st_no_wb", 32'(wbv_a[0]), 32'h0);
        drive(0, 1, 1, 1, 2'd2, 0, 2'd0, 32'h12, 32'hFFFF_FFFF, 8'h0);
        drive(0, 1, 1, 0, 2'd3, 0, 2'd0, 32'h10, 32'h0, 8'h0);
        idle(0, 2);
        chk("t3_word_unchanged", wbd_a[0], 32'h80AD_BEEF);

        // non-memory writeback
        drive(0, 1, 0, 0, 2'd0, 0, 2'd2, 32'h55, 32'h0, 8'hFF);
        chk("t4_no_stall", 32'(stall_a[0]), 32'h0);
        idle(0, 1);
        chk("t4_pc_m1_valid", 32'(wbv_a[0]), 32'h1);
        chk("t4_pc_m1", wbd_a[0], 32'h0);
        drive(0, 1, 0, 0, 2'd0, 0, 2'd2, 32'h55, 32'h0, 8'h05);
        idle(0, 1);
        chk("t4_pc_5", wbd_a[0], 32'h6);
        drive(0, 1, 0, 0, 2'd0, 0, 2'd0, 32'h1234, 32'h0, 8'h05);
        idle(0, 1);
        chk("t4_alu", wbd_a[0], 32'h1234);
        drive(0, 1, 0, 0, 2'd0, 0, 2'd3, 32'hCAFE_0001, 32'h0, 8'h05);
        idle(0, 1);
        chk("t4_sel3_alu", wbd_a[0], 32'hCAFE_0001);

        // latency 3: aliasing store, back-to-back loads
        drive(1, 1, 0, 1, 2'd2, 0, 2'd0, 32'h410, 32'h1122_3344, 8'h0);
        s0 = stall_cnt[1];
        w0 = wbv_cnt[1];
        drive(1, 1, 1, 0, 2'd2, 0, 2'd0, 32'h10, 32'h0, 8'h0);
        drive(1, 1, 1, 0, 2'd0, 1, 2'd0, 32'h411, 32'h0, 8'h0);
        drive(1, 1, 1, 0, 2'd1, 0, 2'd0, 32'h12, 32'h0, 8'h0);
        idle(1, 2);
        chk("t6_stall_cycles", 32'(stall_cnt[1] - s0), 32'd12);
        chk("t6_wb_pulses", 32'(wbv_cnt[1] - w0), 32'd3);
        chk("t6_last_half", wbd_a[1], 32'h0000_1122);
        chk("t6_model_alias", load_val(1, 32'hABCD_0410, 2'd2, 0), 32'h1122_3344);

        // reset while a load waits
        @(posedge clk); #1;
        rv_a[1] = 1; rd_a[1] = 1; wr_a[1] = 0; sz_a[1] = 2'd2; alu_a[1] = 32'h10;
        stall_set[(1 << 20) + cyc] = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        rv_a[1] = 0;
        #1;
        chk("t5_rst_stall", 32'(stall_a[1]), 32'h0);
        chk("t5_rst_wb_valid", 32'(wbv_a[1]), 32'h0);
        chk("t5_rst_wb_data", wbd_a[1], 32'h0);
        stall_set.delete();
        wbv_set.delete();
        mis_set.delete();
        data_ev.delete();
        last_data[0] = 0;
        last_data[1] = 0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        w0 = wbv_cnt[1];
        idle(1, 6);
        chk("t5_no_wb_after_abort", 32'(wbv_cnt[1] - w0), 32'h0);
        drive(1, 1, 1, 0, 2'd2, 0, 2'd0, 32'h10, 32'h0, 8'h0);
        idle(1, 2);
        chk("t5_load_after_reset", wbd_a[1], 32'h1122_3344);

        // randomized traffic in a 16-word window with random upper address bits
        for (int u = 0; u < 2; u++) begin
            for (int w = 0; w < 16; w++)
                drive(u, 1, 0, 1, 2'd2, 0, 2'd0, 32'(w * 4), $urandom, 8'h0);
            repeat (250) begin
                a = ($urandom & 32'hFFFF_FC00) | $urandom_range(0, 63);
                drive(u, $urandom_range(0, 5) != 0, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                      a, $urandom, 8'($urandom));
            end
            idle(u, 5);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
